// File: rtl/dcache_mem_ctrl_pkg.sv
// rtl/dcache_mem_ctrl_pkg.sv - shared types and helpers for the dcache miss/store controller
package dcache_mem_ctrl_pkg;

  localparam int LSQSZ = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic             valid;
    logic             issued;
    logic [3:0]       mtag;
    logic [12:0]      block;
    logic [2:0]       offset;
    logic [1:0]       size;
    logic [LSQSZ-1:0] gnt;
  } mshr_entry_t;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      BYTE:    return 64'h0000_0000_0000_00ff;
      HALF:    return 64'h0000_0000_0000_ffff;
      WORD:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/dcache_mem_ctrl_if.sv
// rtl/dcache_mem_ctrl_if.sv - dcache, LSQ and memory-bus signals of the miss/store controller
interface dcache_mem_ctrl_if;
  import dcache_mem_ctrl_pkg::*;

  logic             wb_en;
  logic [15:0]      wb_addr;
  logic [63:0]      wb_data;
  logic [1:0]       wb_size;
  logic             wr_en;
  logic [15:0]      wr_addr;
  logic [63:0]      wr_data;
  logic [1:0]       wr_size;
  logic             rd_en;
  logic [15:0]      rd_addr;
  logic [1:0]       rd_size;
  logic [LSQSZ-1:0] rd_gnt;

  logic             mem_gnt;
  logic [3:0]       mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [3:0]       mem2proc_tag;
  bus_command_e     proc2mem_command;
  logic [15:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [1:0]       proc2mem_size;

  logic             mem_wr_en;
  logic [4:0]       mem_wr_idx;
  logic [7:0]       mem_wr_tag;
  logic [63:0]      mem_wr_data;
  logic             ld_done_en;
  logic [LSQSZ-1:0] ld_done_gnt;
  logic [63:0]      ld_done_data;
  logic             full;

  modport slave (
    input  wb_en, wb_addr, wb_data, wb_size,
    input  wr_en, wr_addr, wr_data, wr_size,
    input  rd_en, rd_addr, rd_size, rd_gnt,
    input  mem_gnt, mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data,
    output ld_done_en, ld_done_gnt, ld_done_data, full
  );

  modport master (
    output wb_en, wb_addr, wb_data, wb_size,
    output wr_en, wr_addr, wr_data, wr_size,
    output rd_en, rd_addr, rd_size, rd_gnt,
    output mem_gnt, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data,
    input  ld_done_en, ld_done_gnt, ld_done_data, full
  );

endinterface

// File: rtl/dcache_mem_ctrl_store_fifo.sv
// rtl/dcache_mem_ctrl_store_fifo.sv - 2-push/1-pop store FIFO with a block-address hazard match
module store_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push0_en_i,
  input  logic [15:0]            push0_addr_i,
  input  logic [63:0]            push0_data_i,
  input  logic [1:0]             push0_size_i,
  input  logic                   push1_en_i,
  input  logic [15:0]            push1_addr_i,
  input  logic [63:0]            push1_data_i,
  input  logic [1:0]             push1_size_i,
  input  logic                   pop_i,
  input  logic [12:0]            match_block_i,
  output logic                   match_o,
  output logic [15:0]            head_addr_o,
  output logic [63:0]            head_data_o,
  output logic [1:0]             head_size_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } sq_entry_t;

  sq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, wptr1, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] age [DEPTH];

  // push1 lands behind push0 when both fire, so wb stays ahead of wr
  always_comb begin
    wptr1   = wptr_q + PW'(push0_en_i);
    wptr_d  = wptr1 + PW'(push1_en_i);
    rptr_d  = rptr_q + PW'(pop_i);
    count_d = count_q + (PW+1)'(push0_en_i) + (PW+1)'(push1_en_i) - (PW+1)'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push0_en_i) mem_q[wptr_q] <= '{addr: push0_addr_i, data: push0_data_i, size: push0_size_i};
    if (push1_en_i) mem_q[wptr1]  <= '{addr: push1_addr_i, data: push1_data_i, size: push1_size_i};
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i] = PW'(i) - rptr_q;
      if (({1'b0, age[i]} < count_q) && (mem_q[i].addr[15:3] == match_block_i)) match_o = 1'b1;
    end
  end

  assign head_addr_o = mem_q[rptr_q].addr;
  assign head_data_o = mem_q[rptr_q].data;
  assign head_size_o = mem_q[rptr_q].size;
  assign count_o     = count_q;

endmodule

// File: rtl/dcache_mem_ctrl.sv
// rtl/dcache_mem_ctrl.sv - dcache miss/store controller: MSHRs, bus issue select and fill return
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int SQ_DEPTH = 4,
  parameter int MSHR_NUM = 4,
  parameter int LSQSZ    = dcache_mem_ctrl_pkg::LSQSZ
) (
  input logic              clock,
  input logic              reset,
  dcache_mem_ctrl_if.slave bus
);

  localparam int MW = $clog2(MSHR_NUM);
  localparam int CW = $clog2(SQ_DEPTH) + 1;
  localparam logic [CW-1:0] SQ_FULL_AT = CW'(SQ_DEPTH - 1);

  mshr_entry_t          mshr_q [MSHR_NUM];
  mshr_entry_t          mshr_d [MSHR_NUM];
  // older_q[i][j] set: entry j was allocated before entry i
  logic [MSHR_NUM-1:0]  older_q [MSHR_NUM];
  logic [MSHR_NUM-1:0]  older_d [MSHR_NUM];
  logic [MSHR_NUM-1:0]  valid_v, pend_v;
  logic [MW-1:0]        ld_idx, alloc_idx, ret_idx;
  logic                 ld_found, alloc_found, ret_hit;
  mshr_entry_t          ret_e;

  logic                 sq_match, sq_pop, accept;
  logic [15:0]          sq_addr;
  logic [63:0]          sq_data;
  logic [1:0]           sq_size;
  logic [CW-1:0]        sq_count;
  bus_command_e         cmd;

  logic                 mem_wr_en_q, ld_done_en_q;
  logic [4:0]           mem_wr_idx_q;
  logic [7:0]           mem_wr_tag_q;
  logic [63:0]          mem_wr_data_q, ld_done_data_q;
  logic [LSQSZ-1:0]     ld_done_gnt_q;

  store_fifo #(.DEPTH(SQ_DEPTH)) u_store_fifo (
    .clk_i         (clock),
    .rst_i         (reset),
    .push0_en_i    (bus.wb_en),
    .push0_addr_i  (bus.wb_addr),
    .push0_data_i  (bus.wb_data),
    .push0_size_i  (bus.wb_size),
    .push1_en_i    (bus.wr_en),
    .push1_addr_i  (bus.wr_addr),
    .push1_data_i  (bus.wr_data),
    .push1_size_i  (bus.wr_size),
    .pop_i         (sq_pop),
    .match_block_i (mshr_q[ld_idx].block),
    .match_o       (sq_match),
    .head_addr_o   (sq_addr),
    .head_data_o   (sq_data),
    .head_size_o   (sq_size),
    .count_o       (sq_count)
  );

  always_comb begin
    ld_found    = 1'b0;
    ld_idx      = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    ret_hit     = 1'b0;
    ret_idx     = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      valid_v[i] = mshr_q[i].valid;
      pend_v[i]  = mshr_q[i].valid && !mshr_q[i].issued;
    end
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (pend_v[i] && !(|(older_q[i] & pend_v))) begin
        ld_found = 1'b1;
        ld_idx   = MW'(i);
      end
      if (mshr_q[i].valid && mshr_q[i].issued && (bus.mem2proc_tag != 4'd0) &&
          (mshr_q[i].mtag == bus.mem2proc_tag)) begin
        ret_hit = 1'b1;
        ret_idx = MW'(i);
      end
    end
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (!valid_v[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = MW'(i);
      end
    end
  end

  assign ret_e = mshr_q[ret_idx];

  // a pending load yields to the store FIFO while any queued store hits its block
  always_comb begin
    cmd               = BUS_NONE;
    bus.proc2mem_addr = '0;
    bus.proc2mem_data = '0;
    bus.proc2mem_size = '0;
    if (bus.mem_gnt) begin
      if (ld_found && !sq_match) begin
        cmd               = BUS_LOAD;
        bus.proc2mem_addr = {mshr_q[ld_idx].block, 3'b000};
        bus.proc2mem_size = DOUBLE;
      end else if (sq_count != '0) begin
        cmd               = BUS_STORE;
        bus.proc2mem_addr = sq_addr;
        bus.proc2mem_data = sq_data;
        bus.proc2mem_size = sq_size;
      end
    end
  end

  assign bus.proc2mem_command = cmd;
  assign accept               = (cmd != BUS_NONE) && (bus.mem2proc_response != 4'd0);
  assign sq_pop               = accept && (cmd == BUS_STORE);
  assign bus.full             = (sq_count >= SQ_FULL_AT) || (&valid_v);

  always_comb begin
    mshr_d  = mshr_q;
    older_d = older_q;
    if (accept && (cmd == BUS_LOAD)) begin
      mshr_d[ld_idx].issued = 1'b1;
      mshr_d[ld_idx].mtag   = bus.mem2proc_response;
    end
    if (ret_hit) begin
      mshr_d[ret_idx].valid  = 1'b0;
      mshr_d[ret_idx].issued = 1'b0;
    end
    if (bus.rd_en && alloc_found) begin
      mshr_d[alloc_idx] = '{valid: 1'b1, issued: 1'b0, mtag: 4'd0, block: bus.rd_addr[15:3],
                            offset: bus.rd_addr[2:0], size: bus.rd_size, gnt: bus.rd_gnt};
      older_d[alloc_idx] = valid_v;
      for (int j = 0; j < MSHR_NUM; j++) older_d[j][alloc_idx] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_NUM; i++) begin
        mshr_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      mshr_q  <= mshr_d;
      older_q <= older_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_wr_en_q    <= 1'b0;
      mem_wr_idx_q   <= '0;
      mem_wr_tag_q   <= '0;
      mem_wr_data_q  <= '0;
      ld_done_en_q   <= 1'b0;
      ld_done_gnt_q  <= '0;
      ld_done_data_q <= '0;
    end else begin
      mem_wr_en_q  <= ret_hit;
      ld_done_en_q <= ret_hit;
      if (ret_hit) begin
        mem_wr_idx_q   <= ret_e.block[4:0];
        mem_wr_tag_q   <= ret_e.block[12:5];
        mem_wr_data_q  <= bus.mem2proc_data;
        ld_done_gnt_q  <= ret_e.gnt;
        ld_done_data_q <= (bus.mem2proc_data >> {ret_e.offset, 3'b000}) & size_mask(ret_e.size);
      end
    end
  end

  assign bus.mem_wr_en    = mem_wr_en_q;
  assign bus.mem_wr_idx   = mem_wr_idx_q;
  assign bus.mem_wr_tag   = mem_wr_tag_q;
  assign bus.mem_wr_data  = mem_wr_data_q;
  assign bus.ld_done_en   = ld_done_en_q;
  assign bus.ld_done_gnt  = ld_done_gnt_q;
  assign bus.ld_done_data = ld_done_data_q;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb/tb_dcache_mem_ctrl.sv - directed scoreboard bench for dcache_mem_ctrl
module tb_dcache_mem_ctrl;
  import dcache_mem_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dcache_mem_ctrl_if bus ();

  dcache_mem_ctrl #(.SQ_DEPTH(4), .MSHR_NUM(4), .LSQSZ(LSQSZ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]       cmd;
    logic [15:0]      addr;
    logic [63:0]      data;
    logic [1:0]       size;
    logic [15:0]      rd_addr;
    logic [1:0]       rd_size;
    logic [LSQSZ-1:0] gnt;
  } bus_exp_t;

  typedef struct {
    logic [4:0]       idx;
    logic [7:0]       tag;
    logic [63:0]      data;
    logic [LSQSZ-1:0] gnt;
    logic [63:0]      ld;
  } fill_exp_t;

  int        checks = 0;
  int        errors = 0;
  bus_exp_t  bus_q[$];
  fill_exp_t fill_q[$];
  bus_exp_t  inflight [16];
  bit        inflight_v [16];
  fill_exp_t mon_f;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic fill_exp_t mk_fill(input logic [15:0] a, input logic [1:0] sz,
                                        input logic [LSQSZ-1:0] g, input logic [63:0] d);
    fill_exp_t f;
    int        off;
    logic [63:0] sh;
    off = int'(a[2:0]);
    sh  = d >> (off * 8);
    case (sz)
      2'd0:    sh = sh & 64'hff;
      2'd1:    sh = sh & 64'hffff;
      2'd2:    sh = sh & 64'hffff_ffff;
      default: sh = sh;
    endcase
    f.idx  = a[7:3];
    f.tag  = a[15:8];
    f.data = d;
    f.gnt  = g;
    f.ld   = sh;
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_req();
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.wb_size = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_size = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_size = '0; bus.rd_gnt = '0;
  endtask

  task automatic push_wb(input logic [15:0] a, input logic [63:0] d, input logic [1:0] s);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d; bus.wb_size = s;
    bus_q.push_back('{cmd: BUS_STORE, addr: a, data: d, size: s, rd_addr: '0, rd_size: '0, gnt: '0});
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [63:0] d, input logic [1:0] s);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_size = s;
    bus_q.push_back('{cmd: BUS_STORE, addr: a, data: d, size: s, rd_addr: '0, rd_size: '0, gnt: '0});
  endtask

  task automatic push_rd(input logic [15:0] a, input logic [1:0] s, input logic [LSQSZ-1:0] g);
    bus.rd_en = 1'b1; bus.rd_addr = a; bus.rd_size = s; bus.rd_gnt = g;
    bus_q.push_back('{cmd: BUS_LOAD, addr: {a[15:3], 3'b000}, data: '0, size: DOUBLE,
                      rd_addr: a, rd_size: s, gnt: g});
  endtask

  task automatic issue(input logic [3:0] resp);
    bus_exp_t e;
    bus.mem_gnt = 1'b1;
    bus.mem2proc_response = resp;
    #1;
    if (bus_q.size() == 0) begin
      chk("bus_queue_empty", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    end else begin
      e = bus_q[0];
      chk("bus_cmd", 64'(bus.proc2mem_command), 64'(e.cmd));
      chk("bus_addr", 64'(bus.proc2mem_addr), 64'(e.addr));
      chk("bus_data", bus.proc2mem_data, e.data);
      chk("bus_size", 64'(bus.proc2mem_size), 64'(e.size));
      if (resp != 4'd0) begin
        void'(bus_q.pop_front());
        if (e.cmd == BUS_LOAD) begin
          inflight[resp]   = e;
          inflight_v[resp] = 1'b1;
        end
      end
    end
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem2proc_response = '0;
  endtask

  task automatic check_none(input string name);
    bus.mem_gnt = 1'b1;
    #1;
    chk(name, 64'(bus.proc2mem_command), 64'(BUS_NONE));
    bus.mem_gnt = 1'b0;
  endtask

  task automatic ret_drive(input logic [3:0] tag, input logic [63:0] d);
    bus.mem2proc_tag  = tag;
    bus.mem2proc_data = d;
    if (inflight_v[tag]) begin
      fill_q.push_back(mk_fill(inflight[tag].rd_addr, inflight[tag].rd_size, inflight[tag].gnt, d));
      inflight_v[tag] = 1'b0;
    end
  endtask

  task automatic ret_clear();
    bus.mem2proc_tag  = '0;
    bus.mem2proc_data = '0;
  endtask

  task automatic ret(input logic [3:0] tag, input logic [63:0] d);
    ret_drive(tag, d);
    tick();
    ret_clear();
  endtask

  always @(negedge clock) begin
    if (!reset && (bus.wb_en || bus.wr_en || bus.rd_en)) chk("push_while_full", 64'(bus.full), 64'd0);
    if (bus.mem_wr_en || bus.ld_done_en) begin
      if (fill_q.size() == 0) begin
        chk("unexpected_fill", {62'd0, bus.mem_wr_en, bus.ld_done_en}, 64'd0);
      end else begin
        mon_f = fill_q.pop_front();
        chk("fill_wr_en", 64'(bus.mem_wr_en), 64'd1);
        chk("fill_ld_en", 64'(bus.ld_done_en), 64'd1);
        chk("fill_idx", 64'(bus.mem_wr_idx), 64'(mon_f.idx));
        chk("fill_tag", 64'(bus.mem_wr_tag), 64'(mon_f.tag));
        chk("fill_data", bus.mem_wr_data, mon_f.data);
        chk("ld_gnt", 64'(bus.ld_done_gnt), 64'(mon_f.gnt));
        chk("ld_data", bus.ld_done_data, mon_f.ld);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) inflight_v[i] = 1'b0;
    idle_req();
    bus.mem_gnt = 1'b0; bus.mem2proc_response = '0; ret_clear();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_mem_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("rst_ld_done_en", 64'(bus.ld_done_en), 64'd0);
    chk("rst_ld_done_data", bus.ld_done_data, 64'd0);
    check_none("rst_cmd");
    reset = 1'b0;
    tick();

    // read miss round trip
    push_rd(16'h1234, WORD, 4'b0100); tick(); idle_req();
    issue(4'd3);
    ret(4'd3, 64'h1122_3344_5566_7788);
    chk("t1_wr_en", 64'(bus.mem_wr_en), 64'd1);
    chk("t1_idx", 64'(bus.mem_wr_idx), 64'd6);
    chk("t1_tag", 64'(bus.mem_wr_tag), 64'h12);
    chk("t1_ld_data", bus.ld_done_data, 64'h1122_3344);
    chk("t1_ld_gnt", 64'(bus.ld_done_gnt), 64'b0100);
    tick();
    chk("t1_pulse", 64'(bus.mem_wr_en), 64'd0);

    // dual push ordering and store-FIFO full threshold
    push_wb(16'h0100, 64'hA0A0_0000_0000_0001, DOUBLE);
    push_wr(16'h0208, 64'hB1B1_0000_0000_0002, WORD);
    tick(); idle_req();
    chk("t2_full_two", 64'(bus.full), 64'd0);
    push_wb(16'h0110, 64'hC2C2_0000_0000_0003, HALF); tick(); idle_req();
    chk("t2_full_three", 64'(bus.full), 64'd1);
    issue(4'd0);
    chk("t2_full_rej", 64'(bus.full), 64'd1);
    issue(4'd5);
    chk("t2_full_pop", 64'(bus.full), 64'd0);
    issue(4'd6);
    issue(4'd7);
    check_none("t2_drained");

    // RAW hazard: store to same block goes out before the load
    push_wb(16'h0040, 64'hD3D3_0000_0000_0004, DOUBLE); tick(); idle_req();
    push_rd(16'h0044, WORD, 4'b0001); tick(); idle_req();
    issue(4'd7);
    issue(4'd2);
    ret(4'd2, 64'hCAFE_BABE_DEAD_BEEF);
    tick();

    // rejection retry, load priority over an unrelated store
    push_rd(16'h0500, BYTE, 4'b0010);
    push_wb(16'h0300, 64'hE4E4_0000_0000_0005, WORD);
    tick(); idle_req();
    issue(4'd0); issue(4'd0); issue(4'd0);
    chk("t4_full", 64'(bus.full), 64'd0);
    issue(4'd4);
    issue(4'd9);
    check_none("t4_drained");
    ret(4'd4, 64'h0123_4567_89AB_CDEF);
    tick();

    // MSHR full, free on return, slot reuse
    for (int i = 0; i < 4; i++) begin
      chk("t5_not_full", 64'(bus.full), 64'd0);
      push_rd(16'(16'h1000 + 8 * i), DOUBLE, 4'(1 << i)); tick(); idle_req();
    end
    chk("t5_full", 64'(bus.full), 64'd1);
    for (int i = 0; i < 4; i++) issue(4'(i + 1));
    ret_drive(4'd2, 64'h2222_0000_1111_0000);
    chk("t5_full_during_ret", 64'(bus.full), 64'd1);
    tick(); ret_clear();
    chk("t5_full_drop", 64'(bus.full), 64'd0);
    push_rd(16'h2000, HALF, 4'b0010); tick(); idle_req();
    chk("t5_refull", 64'(bus.full), 64'd1);
    issue(4'd5);
    ret(4'd5, 64'h0000_0000_0000_ABCD);
    ret(4'd4, 64'h4444_4444_4444_4444);
    tick();

    // reset with tags 1 and 3 still in flight
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 16; i++) inflight_v[i] = 1'b0;
    bus_q.delete();
    chk("t6_full", 64'(bus.full), 64'd0);
    ret(4'd1, 64'h1111_1111_1111_1111);
    chk("t6_no_fill_1", 64'(bus.mem_wr_en), 64'd0);
    chk("t6_no_ld_1", 64'(bus.ld_done_en), 64'd0);
    ret(4'd3, 64'h3333_3333_3333_3333);
    chk("t6_no_fill_3", 64'(bus.mem_wr_en), 64'd0);
    chk("t6_no_ld_3", 64'(bus.ld_done_en), 64'd0);
    check_none("t6_idle");
    tick(); tick();
    chk("fills_drained", 64'(fill_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
